// File: rtl/muldiv_pkg.sv
// Shared op codes and state encoding for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_absneg.sv
// Combinational conditional two's-complement negate, used for operand
// magnitudes and for the final sign fixup of products, quotients and remainders.
module muldiv_absneg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? (~x + WIDTH'(1)) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with integrated HI/LO registers,
// start/busy/done handshake, cancel for exception flush and divide-by-zero flag.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               dz_q, dz_d;
  logic               qsign_q, qsign_d;
  logic               rsign_q, rsign_d;
  // Upper accumulator: product high half (mul) or WIDTH+1-bit partial remainder (div).
  logic [WIDTH:0]     acc_hi_q, acc_hi_d;
  // Lower accumulator: multiplier shifting out / product low half, or dividend / quotient.
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   opd_q, opd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic               op_signed;
  logic               launch;
  logic               b_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh, rem_sub;
  logic               rem_ge;

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign launch    = start && !cancel;
  assign b_zero    = (b == '0);

  muldiv_absneg #(.WIDTH(WIDTH)) u_abs_a (.x(a), .neg(op_signed & a[WIDTH-1]), .y(a_mag));
  muldiv_absneg #(.WIDTH(WIDTH)) u_abs_b (.x(b), .neg(op_signed & b[WIDTH-1]), .y(b_mag));

  muldiv_absneg #(.WIDTH(2*WIDTH)) u_fix_prod (
    .x({acc_hi_q[WIDTH-1:0], acc_lo_q}), .neg(qsign_q), .y(prod_fix)
  );
  muldiv_absneg #(.WIDTH(WIDTH)) u_fix_quo (.x(acc_lo_q), .neg(qsign_q), .y(quo_fix));
  muldiv_absneg #(.WIDTH(WIDTH)) u_fix_rem (.x(acc_hi_q[WIDTH-1:0]), .neg(rsign_q), .y(rem_fix));

  // Shift-add step: acc_hi_q[WIDTH] is always 0 on the multiply path.
  assign mul_sum = acc_hi_q + (acc_lo_q[0] ? {1'b0, opd_q} : '0);

  // Restoring divide step, one quotient bit per edge, MSB first.
  assign rem_sh  = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
  assign rem_ge  = (rem_sh >= {1'b0, opd_q});
  assign rem_sub = rem_sh - {1'b0, opd_q};

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      dz_q       <= 1'b0;
      qsign_q    <= 1'b0;
      rsign_q    <= 1'b0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opd_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      dz_q       <= dz_d;
      qsign_q    <= qsign_d;
      rsign_q    <= rsign_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      opd_q      <= opd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (launch && !op[2]) state_d = (op[1] && b_zero) ? ST_FIX : ST_CALC;
      end
      ST_CALC: begin
        if (cancel)                 state_d = ST_IDLE;
        else if (cnt_q == LAST_CNT) state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  always_comb begin
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    dz_d       = dz_q;
    qsign_d    = qsign_q;
    rsign_d    = rsign_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opd_d      = opd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end else if (!op[2]) begin
            is_div_d = op[1];
            cnt_d    = '0;
            if (op[1] && b_zero) begin
              // Preload so the ordinary divide fixup yields hi=a, lo=all ones.
              dz_d     = 1'b1;
              qsign_d  = 1'b0;
              rsign_d  = 1'b0;
              acc_hi_d = {1'b0, a};
              acc_lo_d = '1;
            end else begin
              dz_d     = 1'b0;
              qsign_d  = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              rsign_d  = op_signed & a[WIDTH-1];
              acc_hi_d = '0;
              acc_lo_d = op[1] ? a_mag : b_mag;
              opd_d    = op[1] ? b_mag : a_mag;
            end
          end
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div_q) begin
          acc_hi_d = rem_ge ? rem_sub : rem_sh;
          acc_lo_d = {acc_lo_q[WIDTH-2:0], rem_ge};
        end else begin
          acc_hi_d = {1'b0, mul_sum[WIDTH:1]};
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
      end
      ST_FIX: begin
        if (!cancel) begin
          hi_d       = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
          lo_d       = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
          done_d     = 1'b1;
          div_zero_d = dz_q;
        end
      end
      default: ;
    endcase
  end

  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model with a
// per-cycle compare, directed scenarios with literal results, then random ops.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic          clk_in = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  a, b;
  logic          cancel;
  logic          busy, done, div_zero;
  logic [W-1:0]  hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model state: remaining busy cycles and the pending result.
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic         m_dz   = 1'b0;
  logic [W-1:0] m_hi   = '0;
  logic [W-1:0] m_lo   = '0;
  logic         p_dz   = 1'b0;
  logic [W-1:0] p_hi   = '0;
  logic [W-1:0] p_lo   = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .cancel   (cancel),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns {div_zero, hi, lo} from plain integer arithmetic.
  function automatic logic [2*W:0] ref_result(input logic [2:0] o, input logic [W-1:0] x,
                                              input logic [W-1:0] y);
    logic [63:0] p;
    longint      sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    q  = 0;
    r  = 0;
    if (o == OP_MULT) begin
      p = sx * sy;
      return {1'b0, p};
    end
    if (o == OP_MULTU) begin
      p = {32'd0, x} * {32'd0, y};
      return {1'b0, p};
    end
    if (y == '0) return {1'b1, x, 32'hFFFF_FFFF};
    if (o == OP_DIV) begin
      q = sx / sy;
      r = sx % sy;
    end else begin
      q = longint'(x / y);
      r = longint'(x % y);
    end
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  always @(posedge clk_in or posedge reset) begin
    if (reset) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        if (cancel) begin
          m_left <= 0;
        end else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_hi   <= p_hi;
            m_lo   <= p_lo;
            m_dz   <= p_dz;
            m_done <= 1'b1;
          end
        end
      end else if (start && !cancel) begin
        if (op == OP_MTHI) m_hi <= a;
        else if (op == OP_MTLO) m_lo <= a;
        else if (!op[2]) begin
          {p_dz, p_hi, p_lo} <= ref_result(op, a, b);
          m_left <= (op[1] && b == '0) ? 1 : W + 1;
        end
      end
    end
  end

  always @(negedge clk_in) begin
    if (chk_en && !reset) begin
      check("busy", 64'(busy), 64'(m_left != 0));
      check("done", 64'(done), 64'(m_done));
      check("div_zero", 64'(div_zero), 64'(m_dz));
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic check_hl(input string nm, input logic [W-1:0] eh, input logic [W-1:0] el);
    check({nm, "_hi"}, 64'(hi), 64'(eh));
    check({nm, "_lo"}, 64'(lo), 64'(el));
    check({nm, "_model_hi"}, 64'(m_hi), 64'(eh));
    check({nm, "_model_lo"}, 64'(m_lo), 64'(el));
  endtask

  // Issues one op and returns the number of busy cycles observed.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input int intr_at, input int cancel_at, output int n);
    @(negedge clk_in);
    start = 1'b1; op = o; a = aa; b = bb; cancel = 1'b0;
    @(negedge clk_in);
    start = 1'b0; a = $urandom; b = $urandom;
    n = 0;
    while (busy && n < 200) begin
      n++;
      if (n == intr_at) begin
        start = 1'b1;
        op    = 3'($urandom_range(0, 5));
      end else begin
        start = 1'b0;
      end
      cancel = (n == cancel_at);
      @(negedge clk_in);
    end
    start = 1'b0; cancel = 1'b0;
    if (n >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL busy_timeout: busy still high after %0d cycles, required to fall", n);
    end else if (!o[2] && (cancel_at == 0 || cancel_at > n)) begin
      check("done_pulse", 64'(done), 64'd1);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 8)
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk_in);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_div_zero", 64'(div_zero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset  = 1'b0;
    chk_en = 1'b1;

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 0, 0, n);
    check("mult_busy_cycles", 64'(n), 64'd33);
    check_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, n);
    check_hl("multu", 32'hFFFF_FFFE, 32'h0000_0001);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, n);
    check_hl("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(OP_DIVU, 32'd7, 32'd2, 0, 0, n);
    check_hl("divu", 32'd1, 32'd3);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, n);
    check_hl("div_ovf", 32'd0, 32'h8000_0000);

    run_op(OP_DIVU, 32'd5, 32'd0, 0, 0, n);
    check("divz_busy_cycles", 64'(n), 64'd1);
    check("divz_flag", 64'(div_zero), 64'd1);
    check_hl("divz", 32'd5, 32'hFFFF_FFFF);
    run_op(OP_MULTU, 32'd2, 32'd3, 0, 0, n);
    check("divz_cleared", 64'(div_zero), 64'd0);
    check_hl("multu_small", 32'd0, 32'd6);

    run_op(OP_MTHI, 32'h1234, 32'd0, 0, 0, n);
    check("mthi_busy_cycles", 64'(n), 64'd0);
    check("mthi_hi", 64'(hi), 64'h1234);
    run_op(OP_MTLO, 32'h5678, 32'd0, 0, 0, n);
    check("mtlo_busy_cycles", 64'(n), 64'd0);
    check_hl("mtxx", 32'h1234, 32'h5678);

    run_op(OP_MULT, 32'd9, 32'd9, 0, 10, n);
    check("cancel_busy_cycles", 64'(n), 64'd10);
    check("cancel_done", 64'(done), 64'd0);
    check_hl("cancel_keep", 32'h1234, 32'h5678);

    run_op(OP_DIVU, 32'd100, 32'd7, 5, 0, n);
    check("restart_ignored_cycles", 64'(n), 64'd33);
    check_hl("restart_div", 32'd2, 32'd14);

    // Asynchronous reset pulse between clock edges during a DIV.
    @(negedge clk_in);
    start = 1'b1; op = OP_DIV; a = 32'hFFFF_FF9C; b = 32'd3;
    @(negedge clk_in);
    start = 1'b0;
    repeat (5) @(negedge clk_in);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_div_zero", 64'(div_zero), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    #1 reset = 1'b0;
    run_op(OP_MULTU, 32'd2, 32'd3, 0, 0, n);
    check_hl("post_rst", 32'd0, 32'd6);

    for (int i = 0; i < 300; i++) begin
      int ia, ca;
      if ($urandom % 10 == 0) begin
        @(negedge clk_in);
        start = 1'b1; cancel = 1'b1; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
        @(negedge clk_in);
        start = 1'b0; cancel = 1'b0;
      end
      ia = ($urandom % 4 == 0) ? int'($urandom_range(1, 30)) : 0;
      ca = ($urandom % 6 == 0) ? int'($urandom_range(1, 34)) : 0;
      run_op(3'($urandom_range(0, 7)), pick(), pick(), ia, ca, n);
      repeat ($urandom_range(0, 2)) @(negedge clk_in);
    end

    @(negedge clk_in);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
